// File: rtl/fifo_ram_fwft_pkg.sv
// fifo_ram_fwft_pkg: shared address-width helper and read-mode constants
package fifo_ram_fwft_pkg;
  localparam int MODE_STD = 0;
  localparam int MODE_FWFT = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram_fwft_if.sv
// fifo_ram_fwft_if: FIFO write/read handshake, status flags and sticky errors
// master drives i_* (writer/reader side), slave is the FIFO driving o_*
interface fifo_ram_fwft_if import fifo_ram_fwft_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int CW = clog2(DEPTH) + 1;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_wr_en;
  logic             i_rd_en;
  logic             i_clr_err;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             o_empty;
  logic             o_full;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;
  modport master (
    output i_wr_data, i_wr_en, i_rd_en, i_clr_err,
    input  o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
  modport slave (
    input  i_wr_data, i_wr_en, i_rd_en, i_clr_err,
    output o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_ram_mem.sv
// fifo_ram_mem: simple dual-port RAM, sync write, async read plus registered read
// ports: clk, rst_n (output register only), we/waddr/wdata, raddr, re,
//        rdata_async (zero latency), rdata_reg (updated on re, else held)
module fifo_ram_mem #(
  parameter int WIDTH = 8,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  input  logic             re,
  output logic [WIDTH-1:0] rdata_async,
  output logic [WIDTH-1:0] rdata_reg
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata_async = mem[raddr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_reg <= '0;
    else if (re) rdata_reg <= mem[raddr];
endmodule

// File: rtl/fifo_ram_fwft.sv
// fifo_ram_fwft: synchronous RAM FIFO with standard or first-word-fall-through read
// ports: i_clk, i_rst_n (async active-low), bus (slave): write/read requests,
//        read data/valid, empty/full/almost flags, count, sticky overflow/underflow
module fifo_ram_fwft import fifo_ram_fwft_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int FWFT = MODE_STD,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  fifo_ram_fwft_if.slave  bus
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0]    wr_ptr, rd_ptr, count;
  logic             empty, full, wr_acc, rd_acc, rd_pulse, ovf, unf;
  logic [WIDTH-1:0] rd_async, rd_reg;
  // the extra MSB of each pointer tells a full ring from an empty one
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_acc = bus.i_wr_en && !full;
  assign rd_acc = bus.i_rd_en && !empty;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_pulse <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_acc);
      rd_ptr <= rd_ptr + PW'(rd_acc);
      count <= count + PW'(wr_acc) - PW'(rd_acc);
      rd_pulse <= rd_acc;
      // a new error in the same cycle as a clear keeps the flag set
      ovf <= (bus.i_wr_en && full) || (ovf && !bus.i_clr_err);
      unf <= (bus.i_rd_en && empty) || (unf && !bus.i_clr_err);
    end
  fifo_ram_mem #(.WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .we(wr_acc),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(bus.i_wr_data),
    .raddr(rd_ptr[AW-1:0]),
    .re(rd_acc),
    .rdata_async(rd_async),
    .rdata_reg(rd_reg)
  );
  // fall-through data is masked while empty so reset shows zero, not stale RAM
  assign bus.o_rd_data = (FWFT == MODE_FWFT) ? (empty ? '0 : rd_async) : rd_reg;
  assign bus.o_rd_valid = (FWFT == MODE_FWFT) ? !empty : rd_pulse;
  assign bus.o_empty = empty;
  assign bus.o_full = full;
  assign bus.o_count = count;
  assign bus.o_almost_full = int'(count) >= AF_THRESH;
  assign bus.o_almost_empty = int'(count) <= AE_THRESH;
  assign bus.o_overflow = ovf;
  assign bus.o_underflow = unf;
endmodule
